// File: rtl/display_pkg.sv
// Package for the LC-3 display controller.
// Holds the FSM state type, the default DSR/DDR addresses, the DSR bit
// indices and a helper that assembles the DSR read value.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    HOLD   = 2'd2,
    BUSY   = 2'd3
  } state_t;

  localparam logic [15:0] DSR_ADDR_DEF = 16'hFE04;
  localparam logic [15:0] DDR_ADDR_DEF = 16'hFE06;

  localparam int READY_BIT = 15;
  localparam int IE_BIT    = 14;
  localparam int OVR_BIT   = 13;

  // DSR layout: {ready, ie, ovr, 13'b0}
  function automatic logic [15:0] pack_dsr(input logic ready, input logic ie, input logic ovr);
    logic [15:0] v;
    v            = 16'h0000;
    v[READY_BIT] = ready;
    v[IE_BIT]    = ie;
    v[OVR_BIT]   = ovr;
    return v;
  endfunction

endpackage

// File: rtl/display_if.sv
// Bus + output-stage bundle for display_ctrl.
// Signals: addr/we/re/wdata (CPU -> controller), rdata (controller -> CPU,
// combinational), out_data/print (controller -> output stage), and irq
// (controller -> CPU) which only exists when DISPLAY_IRQ_EN is defined.
// Handshake: there is no valid/ready pair; a store is the cycle in which
// we=1 at the clock edge, a load is any cycle with re=1 and rdata is valid
// in that same cycle. Software must poll DSR.ready before storing to DDR.
interface display_if;
  logic [15:0] addr;
  logic        we;
  logic        re;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic [15:0] out_data;
  logic        print;
`ifdef DISPLAY_IRQ_EN
  logic        irq;

  modport master (output addr, output we, output re, output wdata,
                  input rdata, input out_data, input print, input irq);
  modport slave  (input addr, input we, input re, input wdata,
                  output rdata, output out_data, output print, output irq);
`else
  modport master (output addr, output we, output re, output wdata,
                  input rdata, input out_data, input print);
  modport slave  (input addr, input we, input re, input wdata,
                  output rdata, output out_data, output print);
`endif
endinterface

// File: rtl/display_busy_timer.sv
// busy_timer: saturating down-counter used for the post-print busy window.
// Ports: clk, rst_n (async active-low), i_load (load LOAD_VAL),
// i_dec (decrement, holds at zero), o_zero (count is zero).
module busy_timer #(
  parameter int               WIDTH    = 3,
  parameter logic [WIDTH-1:0] LOAD_VAL = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/display_ctrl.sv
// display_ctrl: memory-mapped LC-3 display controller (DSR/DDR).
// A DDR store in IDLE is latched onto out_data, followed one edge later by a
// one-cycle print pulse, then a BUSY_CYCLES-long window with DSR.ready low.
// DDR stores while not idle are dropped and set the sticky DSR.ovr bit,
// which a DSR read clears (a simultaneous set wins).
// Ports: clk, rst_n (async active-low), bus (display_if.slave: addr, we, re,
// wdata, rdata, out_data, print[, irq]), o_dbg_state (FSM state).
// Optional feature macro DISPLAY_IRQ_EN: makes DSR.ie writable and adds
// irq = ready & ie; without it ie reads 0 and DSR writes are ignored.
module display_ctrl
  import display_pkg::*;
#(
  parameter logic [15:0] DSR_ADDR    = DSR_ADDR_DEF,
  parameter logic [15:0] DDR_ADDR    = DDR_ADDR_DEF,
  parameter int          BUSY_CYCLES = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  display_if.slave bus,
  output state_t o_dbg_state
);

  localparam int CNT_W = $clog2(BUSY_CYCLES + 1);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_ready;
  logic        r_ovr;
  logic        r_print;
  logic [15:0] r_ddr;
  logic [15:0] r_out_data;
  logic        w_ie;

  logic w_ddr_wr;
  logic w_dsr_rd;
  logic w_ddr_rd;
  logic w_accept;
  logic w_print_set;
  logic w_print_clr;
  logic w_load;
  logic w_dec;
  logic w_ready_set;
  logic w_zero;

  assign w_ddr_wr = bus.we && (bus.addr == DDR_ADDR);
  assign w_dsr_rd = bus.re && (bus.addr == DSR_ADDR);
  assign w_ddr_rd = bus.re && (bus.addr == DDR_ADDR);

  busy_timer #(
    .WIDTH    (CNT_W),
    .LOAD_VAL (CNT_W'(BUSY_CYCLES - 1))
  ) u_busy_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_dec  (w_dec),
    .o_zero (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_print_set  = 1'b0;
    w_print_clr  = 1'b0;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    w_ready_set  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_ddr_wr) begin
          w_accept     = 1'b1;
          w_state_next = STROBE;
        end
      end
      STROBE: begin
        w_print_set  = 1'b1;
        w_state_next = HOLD;
      end
      HOLD: begin
        w_print_clr  = 1'b1;
        w_load       = 1'b1;
        w_state_next = BUSY;
      end
      BUSY: begin
        // The timer saturates, so decrementing on the final edge is harmless.
        w_dec = 1'b1;
        if (w_zero) begin
          w_ready_set  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready    <= 1'b1;
      r_ovr      <= 1'b0;
      r_print    <= 1'b0;
      r_ddr      <= 16'h0000;
      r_out_data <= 16'h0000;
    end else begin
      if (w_accept) begin
        r_ddr      <= bus.wdata;
        r_out_data <= bus.wdata;
        r_ready    <= 1'b0;
      end else if (w_ready_set) begin
        r_ready <= 1'b1;
      end

      if (w_print_set)      r_print <= 1'b1;
      else if (w_print_clr) r_print <= 1'b0;

      // A dropped store and a clearing DSR read in the same cycle leave ovr set.
      if (w_ddr_wr && (r_state != IDLE)) r_ovr <= 1'b1;
      else if (w_dsr_rd)                 r_ovr <= 1'b0;
    end
  end

`ifdef DISPLAY_IRQ_EN
  logic r_ie;
  logic w_dsr_wr;

  assign w_dsr_wr = bus.we && (bus.addr == DSR_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ie <= 1'b0;
    else if (w_dsr_wr) r_ie <= bus.wdata[IE_BIT];
  end

  assign w_ie    = r_ie;
  assign bus.irq = r_ready & r_ie;
`else
  assign w_ie = 1'b0;
`endif

  always_comb begin
    bus.rdata = 16'h0000;
    if (w_dsr_rd)      bus.rdata = pack_dsr(r_ready, w_ie, r_ovr);
    else if (w_ddr_rd) bus.rdata = r_ddr;
  end

  assign bus.out_data = r_out_data;
  assign bus.print    = r_print;
  assign o_dbg_state  = r_state;

endmodule
